// File: rtl/inject_sequencer_pkg.sv
// Shared NoC definitions: network sizing defaults, the injection-sequencer
// state encoding and a timer width helper. Used by the test-packet selector,
// the router tops and the injection sequencer.
package inject_sequencer_pkg;

  localparam int unsigned NOC_N_ROUTERS = 121;   // routers in the network
  localparam int unsigned NOC_PKT_W     = 15;    // 1 emulation/valid bit + 14 payload bits
  localparam int unsigned NOC_ID_W      = 7;     // router index width
  localparam int unsigned NOC_TMO       = 1023;  // delivery timeout in cycles
  localparam int unsigned NOC_STEP_W    = 7;     // width of one step count

  // Test packet as seen on the injection port at default sizing.
  typedef struct packed {
    logic                  emu;
    logic [NOC_STEP_W-1:0] step2;
    logic [NOC_STEP_W-1:0] step1;
  } noc_pkt_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_INJECT = 3'd1,
    ST_WAIT   = 3'd2,
    ST_NEXT   = 3'd3,
    ST_FINISH = 3'd4
  } seq_state_e;

  // Bits needed to hold 0..tmo.
  function automatic int unsigned timer_width(input int unsigned tmo);
    return (tmo < 1) ? 1 : $clog2(tmo + 1);
  endfunction

endpackage

// File: rtl/noc_timeout_timer.sv
// Delivery timeout timer.
//   clk, rst_n : clock, async active-low reset
//   clear_i    : restart counting from zero
//   enable_i   : count this cycle
//   expire_o   : registered; high during the enabled cycle whose closing edge
//                takes the count to TMO, so a consumer sampling it on that
//                edge acts exactly when the timer reaches TMO.
// TMO must be at least 1.
module noc_timeout_timer
  import inject_sequencer_pkg::*;
#(
  parameter int unsigned TMO = NOC_TMO
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam int unsigned TIMER_W = timer_width(TMO);
  localparam logic [TIMER_W-1:0] CNT_TMO  = TIMER_W'(TMO);
  localparam logic [TIMER_W-1:0] CNT_LAST = TIMER_W'(TMO - 1);

  logic [TIMER_W-1:0] count_q, count_d;
  logic               expire_q, expire_d;

  // Count up, stop at TMO.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && (count_q != CNT_TMO)) begin
      count_d = count_q + TIMER_W'(1);
    end
  end

  // Look-ahead flag; dropped whenever counting pauses so it never goes stale.
  always_comb begin
    expire_d = (clear_i || enable_i) && (count_d == CNT_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= '0;
      expire_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      expire_q <= expire_d;
    end
  end

  assign expire_o = expire_q;

endmodule

// File: rtl/inject_sequencer.sv
// Injection sequencer: injects a latched test packet into one router, or into
// every router in turn, waits for each delivery report or a timeout, and
// tallies passes and failures for the run.
//   start/abort/mode/src_sel/payload : run control
//   inj_valid/inj_router/inj_pkt     : injection port, inj_ready handshake
//   dlv_valid/dlv_src                : delivery reports from the network
//   busy/done/err/pass_cnt/fail_cnt  : run status, all registered
module inject_sequencer
  import inject_sequencer_pkg::*;
#(
  parameter int unsigned N_ROUTERS = NOC_N_ROUTERS,
  parameter int unsigned PKT_W     = NOC_PKT_W,
  parameter int unsigned ID_W      = NOC_ID_W,
  parameter int unsigned TMO       = NOC_TMO
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              mode,
  input  logic [ID_W-1:0]   src_sel,
  input  logic [PKT_W-2:0]  payload,
  input  logic              inj_ready,
  input  logic              dlv_valid,
  input  logic [ID_W-1:0]   dlv_src,
  output logic              inj_valid,
  output logic [ID_W-1:0]   inj_router,
  output logic [PKT_W-1:0]  inj_pkt,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ID_W:0]     pass_cnt,
  output logic [ID_W:0]     fail_cnt
);

  localparam int unsigned PL_W  = PKT_W - 1;
  localparam int unsigned CNT_W = ID_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [ID_W-1:0]  LAST_ID = ID_W'(N_ROUTERS - 1);

  seq_state_e        state_q, state_d;
  logic [ID_W-1:0]   cur_q, cur_d;
  logic [PL_W-1:0]   payload_q, payload_d;
  logic              mode_q, mode_d;
  logic              inj_valid_q, inj_valid_d;
  logic [ID_W-1:0]   inj_router_q, inj_router_d;
  logic [PKT_W-1:0]  inj_pkt_q, inj_pkt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  pass_q, pass_d;
  logic [CNT_W-1:0]  fail_q, fail_d;

  logic tmr_clear, tmr_enable, tmr_expire;
  logic src_ok_c, hs_c, dlv_hit_c;

  assign src_ok_c  = 32'(src_sel) < N_ROUTERS;
  assign hs_c      = (state_q == ST_INJECT) && inj_valid_q && inj_ready;
  assign dlv_hit_c = dlv_valid && (dlv_src == cur_q);

  noc_timeout_timer #(
    .TMO (TMO)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (tmr_clear),
    .enable_i (tmr_enable),
    .expire_o (tmr_expire)
  );

  // Next state and next registered outputs.
  always_comb begin
    state_d      = state_q;
    cur_d        = cur_q;
    payload_d    = payload_q;
    mode_d       = mode_q;
    inj_valid_d  = 1'b0;
    inj_router_d = inj_router_q;
    inj_pkt_d    = '0;
    busy_d       = busy_q;
    done_d       = 1'b0;
    err_d        = 1'b0;
    pass_d       = pass_q;
    fail_d       = fail_q;
    tmr_clear    = 1'b0;
    tmr_enable   = 1'b0;

    if ((state_q != ST_IDLE) && abort) begin
      // Abort wins over every other event; counters keep their tallies.
      state_d = ST_IDLE;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (mode || src_ok_c) begin
              payload_d = payload;
              mode_d    = mode;
              cur_d     = mode ? '0 : src_sel;
              pass_d    = '0;
              fail_d    = '0;
              busy_d    = 1'b1;
              state_d   = ST_INJECT;
            end else begin
              err_d = 1'b1;
            end
          end
        end

        ST_INJECT: begin
          if (hs_c) begin
            tmr_clear = 1'b1;
            state_d   = ST_WAIT;
          end else begin
            // Hold the offer with stable fields until it is taken.
            inj_valid_d  = 1'b1;
            inj_router_d = cur_q;
            inj_pkt_d    = {1'b1, payload_q};
          end
        end

        ST_WAIT: begin
          tmr_enable = 1'b1;
          // A matching report on the expiry edge still counts as a pass.
          if (dlv_hit_c) begin
            pass_d  = (pass_q == CNT_MAX) ? pass_q : pass_q + CNT_W'(1);
            state_d = ST_NEXT;
          end else if (tmr_expire) begin
            fail_d  = (fail_q == CNT_MAX) ? fail_q : fail_q + CNT_W'(1);
            state_d = ST_NEXT;
          end
        end

        ST_NEXT: begin
          if (!mode_q || (cur_q == LAST_ID)) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_FINISH;
          end else begin
            cur_d   = cur_q + ID_W'(1);
            state_d = ST_INJECT;
          end
        end

        ST_FINISH: begin
          state_d = ST_IDLE;
        end

        default: begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cur_q        <= '0;
      payload_q    <= '0;
      mode_q       <= 1'b0;
      inj_valid_q  <= 1'b0;
      inj_router_q <= '0;
      inj_pkt_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      pass_q       <= '0;
      fail_q       <= '0;
    end else begin
      state_q      <= state_d;
      cur_q        <= cur_d;
      payload_q    <= payload_d;
      mode_q       <= mode_d;
      inj_valid_q  <= inj_valid_d;
      inj_router_q <= inj_router_d;
      inj_pkt_q    <= inj_pkt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      pass_q       <= pass_d;
      fail_q       <= fail_d;
    end
  end

  assign inj_valid  = inj_valid_q;
  assign inj_router = inj_router_q;
  assign inj_pkt    = inj_pkt_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign pass_cnt   = pass_q;
  assign fail_cnt   = fail_q;

endmodule

// File: tb/tb_inject_sequencer.sv
// Bench for inject_sequencer: table of single-injection runs plus directed
// sequences for sweep, stalls, stray reports, abort and async reset.
module tb_inject_sequencer;

  localparam int TMO = 1023;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic        mode;
  logic [6:0]  src_sel;
  logic [13:0] payload;
  logic        inj_ready;
  logic        dlv_valid;
  logic [6:0]  dlv_src;
  logic        inj_valid;
  logic [6:0]  inj_router;
  logic [14:0] inj_pkt;
  logic        busy;
  logic        done;
  logic        err;
  logic [7:0]  pass_cnt;
  logic [7:0]  fail_cnt;

  int errors = 0;
  int checks = 0;

  int          resp_delay = -1;
  logic [6:0]  hs_log[$];

  inject_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .mode       (mode),
    .src_sel    (src_sel),
    .payload    (payload),
    .inj_ready  (inj_ready),
    .dlv_valid  (dlv_valid),
    .dlv_src    (dlv_src),
    .inj_valid  (inj_valid),
    .inj_router (inj_router),
    .inj_pkt    (inj_pkt),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .pass_cnt   (pass_cnt),
    .fail_cnt   (fail_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_done(input int budget, output bit seen);
    seen = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Network model: after a handshake, report delivery resp_delay cycles later.
  initial begin
    int         d;
    logic [6:0] r;
    dlv_valid = 1'b0;
    dlv_src   = '0;
    forever begin
      @(negedge clk);
      if (inj_valid === 1'b1 && inj_ready === 1'b1) begin
        d = resp_delay;
        r = inj_router;
        hs_log.push_back(r);
        if (d >= 0) begin
          repeat (d) @(negedge clk);
          dlv_valid = 1'b1;
          dlv_src   = r;
          @(negedge clk);
          dlv_valid = 1'b0;
        end
      end
    end
  end

  typedef struct {
    logic        mode;
    logic [6:0]  src;
    logic [13:0] pl;
    int          dly;
    logic        exp_err;
    logic [6:0]  exp_router;
    logic [14:0] exp_pkt;
    logic [7:0]  exp_pass;
    logic [7:0]  exp_fail;
    int          exp_lat;
  } vec_t;

  // Single-mode run from a table row; called and returns at a falling edge.
  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    bit seen;
    string t;
    t = $sformatf("v%0d", idx);
    resp_delay = v.dly;
    inj_ready  = 1'b1;
    mode       = v.mode;
    src_sel    = v.src;
    payload    = v.pl;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({t, "_err"}, 32'(err), 32'(v.exp_err));
    chk({t, "_busy"}, 32'(busy), 32'(!v.exp_err));
    if (v.exp_err) begin
      @(negedge clk);
      chk({t, "_err_pulse"}, 32'(err), 32'd0);
      chk({t, "_busy_idle"}, 32'(busy), 32'd0);
      return;
    end
    chk({t, "_valid_late"}, 32'(inj_valid), 32'd0);
    @(negedge clk);
    chk({t, "_valid"}, 32'(inj_valid), 32'd1);
    chk({t, "_router"}, 32'(inj_router), 32'(v.exp_router));
    chk({t, "_pkt"}, 32'(inj_pkt), 32'(v.exp_pkt));
    lat = 0;
    for (int c = 0; c < TMO + 20; c++) begin
      @(negedge clk);
      lat++;
      if (pass_cnt != 0 || fail_cnt != 0) break;
    end
    chk({t, "_latency"}, 32'(lat), 32'(v.exp_lat));
    chk({t, "_pass"}, 32'(pass_cnt), 32'(v.exp_pass));
    chk({t, "_fail"}, 32'(fail_cnt), 32'(v.exp_fail));
    wait_done(10, seen);
    chk({t, "_done"}, 32'(seen), 32'd1);
    chk({t, "_busy_at_done"}, 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    chk({t, "_pass_hold"}, 32'(pass_cnt), 32'(v.exp_pass));
    chk({t, "_fail_hold"}, 32'(fail_cnt), 32'(v.exp_fail));
  endtask

  vec_t vecs[7];

  initial begin
    bit seen;
    int done_cnt;
    int bad;

    vecs[0] = '{1'b0, 7'd5,   14'h0203, 10,   1'b0, 7'd5,   15'h4203, 8'd1, 8'd0, 11};
    vecs[1] = '{1'b0, 7'd0,   14'h3FFF, 1,    1'b0, 7'd0,   15'h7FFF, 8'd1, 8'd0, 2};
    vecs[2] = '{1'b0, 7'd120, 14'h0000, 1023, 1'b0, 7'd120, 15'h4000, 8'd1, 8'd0, 1024};
    vecs[3] = '{1'b0, 7'd33,  14'h1555, -1,   1'b0, 7'd33,  15'h5555, 8'd0, 8'd1, 1024};
    vecs[4] = '{1'b0, 7'd77,  14'h2AAA, 1024, 1'b0, 7'd77,  15'h6AAA, 8'd0, 8'd1, 1024};
    vecs[5] = '{1'b0, 7'd121, 14'h0011, -1,   1'b1, 7'd0,   15'h0000, 8'd0, 8'd0, 0};
    vecs[6] = '{1'b0, 7'd127, 14'h0022, -1,   1'b1, 7'd0,   15'h0000, 8'd0, 8'd0, 0};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; mode = 1'b0;
    src_sel = '0; payload = '0; inj_ready = 1'b0;
    #3;
    chk("rst_inj_valid", 32'(inj_valid), 32'd0);
    chk("rst_inj_router", 32'(inj_router), 32'd0);
    chk("rst_inj_pkt", 32'(inj_pkt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_pass", 32'(pass_cnt), 32'd0);
    chk("rst_fail", 32'(fail_cnt), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);
    chk("idle_router_hold", 32'(inj_router), 32'd77);
    chk("idle_pkt_zero", 32'(inj_pkt), 32'd0);

    // Stalled handshake, stray reports and a start while busy.
    resp_delay = -1;
    inj_ready  = 1'b0;
    dlv_valid  = 1'b1; dlv_src = 7'd3;
    @(negedge clk);
    dlv_valid = 1'b0;
    mode = 1'b0; src_sel = 7'd3; payload = 14'h0ABC; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("stall_first_valid", 32'(inj_valid), 32'd0);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (inj_valid !== 1'b1 || inj_router !== 7'd3 || inj_pkt !== 15'h4ABC) bad++;
      if (i == 5) begin start = 1'b1; mode = 1'b1; src_sel = 7'd0; payload = 14'h3FFF; end
      if (i == 6) start = 1'b0;
      if (i == 10) begin dlv_valid = 1'b1; dlv_src = 7'd3; end
      if (i == 11) dlv_valid = 1'b0;
    end
    chk("stall_unstable_cycles", 32'(bad), 32'd0);
    chk("stall_busy", 32'(busy), 32'd1);
    inj_ready = 1'b1;
    @(negedge clk);
    inj_ready = 1'b0;
    chk("stall_taken", 32'(inj_valid), 32'd0);
    chk("stall_pass_ignored", 32'(pass_cnt), 32'd0);
    dlv_valid = 1'b1; dlv_src = 7'd7;
    @(negedge clk);
    dlv_valid = 1'b0;
    @(negedge clk);
    chk("stray_pass", 32'(pass_cnt), 32'd0);
    chk("stray_fail", 32'(fail_cnt), 32'd0);
    dlv_valid = 1'b1; dlv_src = 7'd3;
    @(negedge clk);
    dlv_valid = 1'b0;
    chk("match_pass", 32'(pass_cnt), 32'd1);
    wait_done(10, seen);
    chk("stall_done", 32'(seen), 32'd1);
    @(negedge clk);
    chk("stall_single_inj", 32'(inj_valid), 32'd0);
    chk("stall_fail", 32'(fail_cnt), 32'd0);
    chk("stall_router_hold", 32'(inj_router), 32'd3);

    // Sweep of all routers; src_sel out of range is ignored in this mode.
    hs_log.delete();
    resp_delay = 3;
    inj_ready  = 1'b1;
    mode = 1'b1; src_sel = 7'd127; payload = 14'h1234; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("sweep_err", 32'(err), 32'd0);
    chk("sweep_busy", 32'(busy), 32'd1);
    done_cnt = 0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin done_cnt++; break; end
    end
    repeat (6) begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
    end
    chk("sweep_done_pulses", 32'(done_cnt), 32'd1);
    chk("sweep_inj_count", 32'(hs_log.size()), 32'd121);
    bad = 0;
    for (int i = 0; i < hs_log.size(); i++) if (hs_log[i] !== 7'(i)) bad++;
    chk("sweep_order_errs", 32'(bad), 32'd0);
    chk("sweep_pass", 32'(pass_cnt), 32'd121);
    chk("sweep_fail", 32'(fail_cnt), 32'd0);
    chk("sweep_busy_end", 32'(busy), 32'd0);
    chk("sweep_last_router", 32'(inj_router), 32'd120);

    // Abort in WAIT during a sweep: tallies hold, no done.
    resp_delay = 2;
    mode = 1'b1; src_sel = 7'd0; payload = 14'h0001; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 500; c++) begin
      if (pass_cnt == 8'd3) break;
      @(negedge clk);
    end
    for (int c = 0; c < 20; c++) begin
      if (inj_valid === 1'b1 && inj_ready === 1'b1) break;
      @(negedge clk);
    end
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_valid", 32'(inj_valid), 32'd0);
    chk("abort_pkt", 32'(inj_pkt), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    done_cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
    end
    chk("abort_no_done", 32'(done_cnt), 32'd0);
    chk("abort_pass_hold", 32'(pass_cnt), 32'd3);
    chk("abort_fail_hold", 32'(fail_cnt), 32'd0);

    // Async reset while offering a packet.
    resp_delay = -1;
    inj_ready  = 1'b0;
    mode = 1'b0; src_sel = 7'd11; payload = 14'h0155; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_rst_valid", 32'(inj_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_inj_valid", 32'(inj_valid), 32'd0);
    chk("arst_inj_router", 32'(inj_router), 32'd0);
    chk("arst_inj_pkt", 32'(inj_pkt), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_err", 32'(err), 32'd0);
    chk("arst_pass", 32'(pass_cnt), 32'd0);
    chk("arst_fail", 32'(fail_cnt), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    resp_delay = 1;
    inj_ready = 1'b1;
    mode = 1'b0; src_sel = 7'd2; payload = 14'h0001; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("post_rst_busy", 32'(busy), 32'd1);
    wait_done(40, seen);
    chk("post_rst_done", 32'(seen), 32'd1);
    chk("post_rst_pass", 32'(pass_cnt), 32'd1);
    chk("post_rst_fail", 32'(fail_cnt), 32'd0);
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
